// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the inter-stage pipeline buffers.
//   - ptr_w()          : pointer width for a DEPTH-entry ring (min 1 bit)
//   - pipe_ctl_t       : valid/ready handshake pair
//   - MAX_PIPE_DEPTH   : largest supported buffer depth
//   - *_payload_t      : per-stage packed payloads; a stage instantiates
//                        pipe_stage_fifo with PAYLOAD_W = $bits(<struct>)
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned MAX_PIPE_DEPTH = 16;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_ctl_t;

  // MEM/WB stage payload (64 bits)
  typedef struct packed {
    logic [31:0] exres;
    logic [4:0]  rdid;
    logic        rd_we;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic        diffins;
    logic [11:0] pc;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_wrap_ctr.sv
// ---------------------------------------------------------------------------
// pipe_wrap_ctr
//   Ring pointer for a DEPTH-entry buffer. Advances on inc, returns to 0 on
//   clr, and wraps explicitly from DEPTH-1 to 0 so non-power-of-2 depths work.
// Ports
//   i_clk   in   clock, rising edge
//   i_rst_n in   asynchronous reset, active high
//   inc     in   advance pointer
//   clr     in   synchronous clear (priority over inc)
//   ptr_o   out  current pointer value
// ---------------------------------------------------------------------------
module pipe_wrap_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      inc,
  input  logic                      clr,
  output logic [ptr_w(DEPTH)-1:0]   ptr_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      ptr_o <= '0;
    end else if (clr) begin
      ptr_o <= '0;
    end else if (inc) begin
      ptr_o <= (ptr_o == LAST) ? '0 : ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_fifo.sv
// ---------------------------------------------------------------------------
// pipe_stage_fifo
//   DEPTH-entry FIFO with valid/ready handshake and single-cycle flush, used
//   as the buffer between CPU pipeline stages. Lets the upstream stage keep
//   issuing while the downstream stage stalls.
// Parameters
//   PAYLOAD_W       payload width
//   DEPTH           entries, 1..MAX_PIPE_DEPTH, any value
//   PASS_WHEN_FULL  accept a push while full when a pop happens this cycle
//   CLEAR_ON_FLUSH  zero storage on flush/reset (else only pointers/count)
// Ports
//   i_clk        in   clock, rising edge
//   i_rst_n      in   asynchronous reset, active HIGH
//   flush        in   synchronous kill of all entries (beats push/pop)
//   in_valid_i   in   upstream payload valid
//   in_ready_o   out  stage can accept a payload
//   in_data_i    in   upstream payload
//   out_valid_o  out  head entry valid
//   out_ready_i  in   downstream consumes head
//   out_data_o   out  head payload (from registers only)
//   count_o      out  occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W      = 64,
  parameter int unsigned DEPTH          = 2,
  parameter bit          PASS_WHEN_FULL = 1'b1,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         flush,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [PAYLOAD_W-1:0]         in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PAYLOAD_W-1:0]         out_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  pipe_ctl_t              in_ctl;
  pipe_ctl_t              out_ctl;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [PAYLOAD_W-1:0]   mem [DEPTH];

  assign full        = (count == FULL_CNT);
  assign out_valid_o = (count != '0);
  assign in_ready_o  = (count < FULL_CNT) | (PASS_WHEN_FULL & out_ready_i & full);
  assign count_o     = count;

  assign in_ctl.valid  = in_valid_i;
  assign in_ctl.ready  = in_ready_o;
  assign out_ctl.valid = out_valid_o;
  assign out_ctl.ready = out_ready_i;

  assign push = in_ctl.valid  & in_ctl.ready  & ~flush;
  assign pop  = out_ctl.valid & out_ctl.ready & ~flush;

  // Pointers: flush returns both to slot 0.
  pipe_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (push),
    .clr     (flush),
    .ptr_o   (wr_ptr)
  );

  pipe_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (pop),
    .clr     (flush),
    .ptr_o   (rd_ptr)
  );

  always_ff @(posedge i_clk or posedge i_rst_n) begin
    if (i_rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full with push+pop, wr_ptr == rd_ptr, so the write reuses the slot
  // being vacated; the old head is still presented this cycle.
  generate
    if (CLEAR_ON_FLUSH) begin : g_clr_mem
      always_ff @(posedge i_clk or posedge i_rst_n) begin
        if (i_rst_n) begin
          mem <= '{default: '0};
        end else if (flush) begin
          mem <= '{default: '0};
        end else if (push) begin
          mem[wr_ptr] <= in_data_i;
        end
      end
      assign out_data_o = mem[rd_ptr];
    end else begin : g_keep_mem
      always_ff @(posedge i_clk) begin
        if (push) begin
          mem[wr_ptr] <= in_data_i;
        end
      end
      // Storage is not cleared here, so mask stale data while empty.
      assign out_data_o = out_valid_o ? mem[rd_ptr] : '0;
    end
  endgenerate

`ifndef SYNTHESIS
  a_depth_range : assert property (@(posedge i_clk)
    (DEPTH >= 1) && (DEPTH <= MAX_PIPE_DEPTH));
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst_n)
    !(push && full && !pop));
  a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst_n)
    !(pop && (count == '0)));
  a_count_bound : assert property (@(posedge i_clk) disable iff (i_rst_n)
    count <= FULL_CNT);
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
module tb_pipe_stage_fifo;

  localparam int unsigned W = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  // a: DEPTH=2, b: DEPTH=3, c: DEPTH=1 no pass, d: DEPTH=1 pass
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [W-1:0] a_in_data = '0, a_out_data;
  logic [1:0] a_count;
  logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [W-1:0] b_in_data = '0, b_out_data;
  logic [1:0] b_count;
  logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [W-1:0] c_in_data = '0, c_out_data;
  logic [0:0] c_count;
  logic d_flush = 0, d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
  logic [W-1:0] d_in_data = '0, d_out_data;
  logic [0:0] d_count;

  pipe_stage_fifo #(.PAYLOAD_W(W), .DEPTH(2), .PASS_WHEN_FULL(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count));

  pipe_stage_fifo #(.PAYLOAD_W(W), .DEPTH(3), .PASS_WHEN_FULL(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count));

  pipe_stage_fifo #(.PAYLOAD_W(W), .DEPTH(1), .PASS_WHEN_FULL(1'b0), .CLEAR_ON_FLUSH(1'b1)) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(c_flush),
    .in_valid_i(c_in_valid), .in_ready_o(c_in_ready), .in_data_i(c_in_data),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_data_o(c_out_data),
    .count_o(c_count));

  pipe_stage_fifo #(.PAYLOAD_W(W), .DEPTH(1), .PASS_WHEN_FULL(1'b1), .CLEAR_ON_FLUSH(1'b1)) u_d (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(d_flush),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .in_data_i(d_in_data),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready), .out_data_o(d_out_data),
    .count_o(d_count));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q[$];
    logic mready, mpush, mpop;
    int nxt, c_nxt, d_nxt, c_exp, d_exp, c_pops, d_pops;

    // reset
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_count", a_count, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_data", a_out_data, 0);

    // 1: streaming, DEPTH=2
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hA1; #1;
    chk("t1_ready", a_in_ready, 1);
    tick(); a_in_data = 8'hA2; #1;
    chk("t1_v1", a_out_valid, 1); chk("t1_d1", a_out_data, 8'hA1); chk("t1_c1", a_count, 1);
    tick(); a_in_data = 8'hA3; #1;
    chk("t1_d2", a_out_data, 8'hA2); chk("t1_c2", a_count, 1);
    tick(); a_in_valid = 0; #1;
    chk("t1_d3", a_out_data, 8'hA3); chk("t1_c3", a_count, 1);
    tick(); #1;
    chk("t1_empty_v", a_out_valid, 0); chk("t1_empty_c", a_count, 0);

    // 2: fill while stalled, then pass-through when full
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hB1; #1;
    tick(); a_in_data = 8'hB2; #1;
    chk("t2_c1", a_count, 1);
    tick(); a_in_data = 8'hB3; #1;
    chk("t2_c2", a_count, 2); chk("t2_full_rdy", a_in_ready, 0); chk("t2_head", a_out_data, 8'hB1);
    tick(); #1;
    chk("t2_hold_c", a_count, 2); chk("t2_hold_d", a_out_data, 8'hB1);
    a_out_ready = 1; #1;
    chk("t2_pass_rdy", a_in_ready, 1);
    tick(); a_in_valid = 0; #1;
    chk("t2_pass_c", a_count, 2); chk("t2_o2", a_out_data, 8'hB2);
    tick(); #1;
    chk("t2_o3", a_out_data, 8'hB3); chk("t2_c3", a_count, 1);
    tick(); #1;
    chk("t2_drain", a_count, 0);

    // 4: flush with push and pop requested
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hC1; #1;
    tick(); a_in_data = 8'hC2; #1;
    tick(); a_flush = 1; a_in_data = 8'hFF; a_out_ready = 1; #1;
    chk("t4_pre_c", a_count, 2);
    tick(); a_flush = 0; a_in_valid = 0; a_out_ready = 0; #1;
    chk("t4_c", a_count, 0); chk("t4_v", a_out_valid, 0); chk("t4_d", a_out_data, 0);
    chk("t4_rdy", a_in_ready, 1);
    tick(); #1;
    chk("t4_d_next", a_out_data, 0);
    a_in_valid = 1; a_in_data = 8'hD1; #1;
    tick(); a_in_valid = 0; #1;
    chk("t4_after_d", a_out_data, 8'hD1); chk("t4_after_c", a_count, 1);
    a_out_ready = 1;
    tick(); a_out_ready = 0; #1;
    chk("t4_after_drain", a_count, 0);

    // 5: asynchronous reset mid-cycle
    a_in_valid = 1; a_in_data = 8'hE1; #1;
    tick(); a_in_data = 8'hE2; #1;
    tick(); a_in_valid = 0; #1;
    chk("t5_pre_c", a_count, 2);
    #1 i_rst_n = 1'b1;
    #1;
    chk("t5_rst_v", a_out_valid, 0); chk("t5_rst_c", a_count, 0); chk("t5_rst_d", a_out_data, 0);
    #2 i_rst_n = 1'b0;
    tick(); a_in_valid = 1; a_in_data = 8'h55; #1;
    tick(); a_in_valid = 0; #1;
    chk("t5_push_v", a_out_valid, 1); chk("t5_push_d", a_out_data, 8'h55);
    a_out_ready = 1;
    tick(); a_out_ready = 0; #1;

    // 3: DEPTH=3, toggling out_ready, pointer wrap
    nxt = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      b_out_ready = (cyc % 2 == 0);
      b_in_valid = (nxt < 5);
      b_in_data = 8'(8'h30 + nxt);
      #1;
      mready = (q.size() < 3) || (b_out_ready && q.size() == 3);
      chk("t3_cnt", b_count, q.size());
      chk("t3_rdy", b_in_ready, mready);
      chk("t3_v", b_out_valid, q.size() != 0);
      if (q.size() > 0) chk("t3_data", b_out_data, q[0]);
      mpush = b_in_valid && mready;
      mpop = (q.size() > 0) && b_out_ready;
      if (mpop) void'(q.pop_front());
      if (mpush) begin
        q.push_back(b_in_data);
        nxt++;
      end
      tick();
    end
    b_in_valid = 0; b_out_ready = 0; #1;
    chk("t3_final_c", b_count, 0);

    // 6: DEPTH=1 throughput without and with pass-through
    c_in_valid = 1; c_out_ready = 1; d_in_valid = 1; d_out_ready = 1;
    c_nxt = 0; d_nxt = 0; c_exp = 0; d_exp = 0; c_pops = 0; d_pops = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      c_in_data = 8'(c_nxt);
      d_in_data = 8'(d_nxt);
      #1;
      if (c_out_valid) begin
        chk("t6_p0_data", c_out_data, 8'(c_exp));
        c_exp++; c_pops++;
      end
      if (d_out_valid) begin
        chk("t6_p1_data", d_out_data, 8'(d_exp));
        d_exp++; d_pops++;
      end
      if (c_in_ready) c_nxt++;
      if (d_in_ready) d_nxt++;
      tick();
    end
    c_in_valid = 0; d_in_valid = 0;
    chk("t6_p0_pops", c_pops, 5);
    chk("t6_p1_pops", d_pops, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
